// File: rtl/st_c2h_qsched_pkg.sv
// st_c2h_qsched shared types and helpers.
// Scheduler states, credit width and per-packet credit need.
package st_c2h_pkg;

  localparam int CRED_W = 16;

  typedef enum logic [1:0] {
    SM_ARB   = 2'd0,
    SM_ISSUE = 2'd1,
    SM_WAIT  = 2'd2
  } sched_state_e;

  // Descriptors one packet consumes: ceil(size / 2^bl), min 1.
  function automatic logic [CRED_W-1:0] calc_need(
    input logic [15:0] size,
    input logic [3:0]  bl
  );
    logic [15:0] mask;
    logic [15:0] whole;
    mask  = (16'd1 << bl) - 16'd1;
    whole = size >> bl;
    if (size == 16'd0) return CRED_W'(1);
    return CRED_W'(whole) + CRED_W'(|(size & mask));
  endfunction

endpackage

// File: rtl/st_c2h_qsched_if.sv
// Command handshake between scheduler and C2H generator.
// Master issues commands, slave accepts and reports done.
interface st_c2h_qsched_if #(
  parameter int QID_W       = 2,
  parameter int TM_DSC_BITS = 16
);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [QID_W-1:0]       cmd_qid;
  logic [15:0]            cmd_txr_size;
  logic [TM_DSC_BITS-1:0] cmd_credits;
  logic                   pkt_done;

  modport master (
    output cmd_valid, cmd_qid, cmd_txr_size, cmd_credits,
    input  cmd_ready, pkt_done
  );

  modport slave (
    input  cmd_valid, cmd_qid, cmd_txr_size, cmd_credits,
    output cmd_ready, pkt_done
  );
endinterface

// File: rtl/st_c2h_qsched_rr_arb.sv
// Round-robin picker over NUM_Q eligibility bits.
// Lowest offset from rr_ptr (wrapping) wins.
module st_c2h_rr_arb #(
  parameter int NUM_Q = 4,
  parameter int QID_W = $clog2(NUM_Q)
) (
  input  logic [NUM_Q-1:0] elig,
  input  logic [QID_W-1:0] rr_ptr,
  output logic             grant_valid,
  output logic [QID_W-1:0] grant_qid
);

  int idx;

  // Scan from farthest offset down so the nearest one is kept.
  always_comb begin
    grant_valid = 1'b0;
    grant_qid   = '0;
    idx         = 0;
    for (int i = NUM_Q - 1; i >= 0; i--) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_Q) idx = idx - NUM_Q;
      if (elig[idx]) begin
        grant_valid = 1'b1;
        grant_qid   = QID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/st_c2h_qsched.sv
// Per-queue C2H packet scheduler, one packet in flight.
// Credit-gated round robin feeding the stream generator.
module st_c2h_qsched
  import st_c2h_pkg::*;
#(
  parameter int NUM_Q       = 4,
  parameter int QID_W       = $clog2(NUM_Q),
  parameter int TM_DSC_BITS = CRED_W
) (
  input  logic                   axi_aclk,
  input  logic                   axi_aresetn,
  input  logic                   cfg_wr,
  input  logic [QID_W-1:0]       cfg_qid,
  input  logic [10:0]            cfg_num_pkt,
  input  logic [15:0]            cfg_txr_size,
  input  logic [3:0]             buf_log2,
  input  logic                   credit_updt,
  input  logic [QID_W-1:0]       credit_qid,
  input  logic [TM_DSC_BITS-1:0] credit_in,
  st_c2h_qsched_if.master        cmd,
  output logic [NUM_Q-1:0]       q_pending,
  output logic                   sched_idle,
  output logic                   err_ovf
);

  localparam int SW = TM_DSC_BITS + 2;
  localparam logic [TM_DSC_BITS-1:0] CMAX = '1;

  sched_state_e state_q, state_d;
  logic [QID_W-1:0] rr_q, rr_d;
  logic [QID_W-1:0] cmd_qid_q, cmd_qid_d;
  logic [15:0] cmd_size_q, cmd_size_d;
  logic [TM_DSC_BITS-1:0] cmd_cred_q, cmd_cred_d;
  logic err_ovf_q, err_ovf_d;

  logic [10:0] pend_q [NUM_Q];
  logic [10:0] pend_d [NUM_Q];
  logic [15:0] size_q [NUM_Q];
  logic [15:0] size_d [NUM_Q];
  logic [TM_DSC_BITS-1:0] cred_q [NUM_Q];
  logic [TM_DSC_BITS-1:0] cred_d [NUM_Q];
  logic [TM_DSC_BITS-1:0] need_w [NUM_Q];
  logic [SW-1:0] sum_w [NUM_Q];

  logic [NUM_Q-1:0] elig;
  logic grant_valid;
  logic [QID_W-1:0] grant_qid;
  logic hs;

  for (genvar g = 0; g < NUM_Q; g++) begin : g_q
    assign need_w[g] = TM_DSC_BITS'(calc_need(size_q[g], buf_log2));
    assign q_pending[g] = (pend_q[g] != 11'd0);
    assign elig[g] = q_pending[g] && (cred_q[g] >= need_w[g]);
  end

  st_c2h_rr_arb #(
    .NUM_Q (NUM_Q),
    .QID_W (QID_W)
  ) u_arb (
    .elig        (elig),
    .rr_ptr      (rr_q),
    .grant_valid (grant_valid),
    .grant_qid   (grant_qid)
  );

  assign hs = (state_q == SM_ISSUE) && cmd.cmd_ready;

  assign cmd.cmd_valid    = (state_q == SM_ISSUE);
  assign cmd.cmd_qid      = cmd_qid_q;
  assign cmd.cmd_txr_size = cmd_size_q;
  assign cmd.cmd_credits  = cmd_cred_q;
  assign sched_idle = (state_q == SM_ARB) && (q_pending == '0);
  assign err_ovf    = err_ovf_q;

  // Scheduler FSM: arbitrate, hold command, wait for tlast.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    cmd_qid_d  = cmd_qid_q;
    cmd_size_d = cmd_size_q;
    cmd_cred_d = cmd_cred_q;
    unique case (state_q)
      SM_ARB: begin
        if (grant_valid) begin
          cmd_qid_d  = grant_qid;
          cmd_size_d = size_q[grant_qid];
          cmd_cred_d = need_w[grant_qid];
          rr_d = (grant_qid == QID_W'(NUM_Q - 1)) ? '0
               : grant_qid + 1'b1;
          state_d = SM_ISSUE;
        end
      end
      SM_ISSUE: begin
        if (cmd.cmd_ready) state_d = SM_WAIT;
      end
      SM_WAIT: begin
        if (cmd.pkt_done) state_d = SM_ARB;
      end
      default: state_d = SM_ARB;
    endcase
  end

  // Per-queue credit, pending and size updates.
  always_comb begin
    err_ovf_d = err_ovf_q;
    for (int q = 0; q < NUM_Q; q++) begin
      sum_w[q] = {2'b00, cred_q[q]};
      if (credit_updt && credit_qid == QID_W'(q))
        sum_w[q] = sum_w[q] + {2'b00, credit_in};
      if (hs && cmd_qid_q == QID_W'(q))
        sum_w[q] = sum_w[q] - {2'b00, cmd_cred_q};
      if (sum_w[q][SW-1:TM_DSC_BITS] != 2'b00) begin
        cred_d[q] = CMAX;
        err_ovf_d = 1'b1;
      end else begin
        cred_d[q] = sum_w[q][TM_DSC_BITS-1:0];
      end
      pend_d[q] = pend_q[q];
      size_d[q] = size_q[q];
      if (hs && cmd_qid_q == QID_W'(q))
        pend_d[q] = pend_q[q] - 11'd1;
      if (cfg_wr && cfg_qid == QID_W'(q)) begin
        pend_d[q] = cfg_num_pkt;
        size_d[q] = cfg_txr_size;
      end
    end
  end

  // State and command registers.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q    <= SM_ARB;
      rr_q       <= '0;
      cmd_qid_q  <= '0;
      cmd_size_q <= '0;
      cmd_cred_q <= '0;
      err_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      cmd_qid_q  <= cmd_qid_d;
      cmd_size_q <= cmd_size_d;
      cmd_cred_q <= cmd_cred_d;
      err_ovf_q  <= err_ovf_d;
    end
  end

  // Per-queue register arrays.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      for (int q = 0; q < NUM_Q; q++) begin
        pend_q[q] <= '0;
        size_q[q] <= '0;
        cred_q[q] <= '0;
      end
    end else begin
      for (int q = 0; q < NUM_Q; q++) begin
        pend_q[q] <= pend_d[q];
        size_q[q] <= size_d[q];
        cred_q[q] <= cred_d[q];
      end
    end
  end

endmodule
